// File: rtl/lbm_pkg.sv
// Shared LBM definitions: phase and sequencer state encodings, plus the
// fixed-point Q-format split used by the fin/p/ux/uy datapath blocks.
package lbm_pkg;

    localparam int FRACTIONAL_BITS = 24;
    localparam int INTEGER_BITS    = 8;

    typedef enum logic [1:0] {
        PH_MACRO   = 2'd0,
        PH_COLLIDE = 2'd1,
        PH_STREAM  = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

endpackage

// File: rtl/lbm_step_sequencer_if.sv
// Control/handshake bundle between the step sequencer, the top-level run
// control and the cell datapath.
//   master : sequencer side (drives status, phase, cell issue, bank select)
//   slave  : controller/datapath side (drives start, cell_ready, cell_ack)
interface lbm_step_sequencer_if
    import lbm_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = 8,
    parameter int TIME_COUNT_WIDTH = 3
);
    logic                        start;
    logic                        busy;
    logic                        done;
    phase_t                      phase;
    logic                        cell_valid;
    logic                        cell_ready;
    logic [ADDRESS_WIDTH-1:0]    cell_addr;
    logic                        cell_ack;
    logic                        buf_sel;
    logic [TIME_COUNT_WIDTH-1:0] time_step;
    logic                        err;

    modport master (
        input  start, cell_ready, cell_ack,
        output busy, done, phase, cell_valid, cell_addr, buf_sel, time_step, err
    );

    modport slave (
        output start, cell_ready, cell_ack,
        input  busy, done, phase, cell_valid, cell_addr, buf_sel, time_step, err
    );
endinterface

// File: rtl/lbm_cell_issue_tracker.sv
// Issues lattice cell addresses for one phase and counts completions.
//   i_clk, i_rst      : clock, async active-high reset
//   i_enable          : issuing allowed (sequencer in RUN)
//   i_clear           : zero both counters at the next edge
//   i_cell_ready      : datapath accepts o_cell_addr
//   i_cell_ack        : datapath finished one issued cell
//   o_cell_valid      : o_cell_addr may be transferred
//   o_cell_addr       : cell being issued
//   o_phase_complete  : ack count reaches GRID_DIM at this edge
//   o_err             : sticky, ack seen with nothing outstanding
module lbm_cell_issue_tracker #(
    parameter int GRID_DIM        = 256,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDRESS_WIDTH   = $clog2(GRID_DIM)
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic                     i_clear,
    input  logic                     i_cell_ready,
    input  logic                     i_cell_ack,
    output logic                     o_cell_valid,
    output logic [ADDRESS_WIDTH-1:0] o_cell_addr,
    output logic                     o_phase_complete,
    output logic                     o_err
);
    // One extra bit so the counters can hold GRID_DIM itself.
    localparam int CNT_W = ADDRESS_WIDTH + 1;

    logic [CNT_W-1:0] r_issue_cnt;
    logic [CNT_W-1:0] r_ack_cnt;
    logic [CNT_W-1:0] w_outstanding;
    logic [CNT_W-1:0] w_ack_nxt;
    logic             w_ack_ok;
    logic             w_issue;
    logic             r_err;

    assign w_outstanding = r_issue_cnt - r_ack_cnt;
    // Ack qualification uses the outstanding count from the start of the
    // cycle, so a cell issued this cycle cannot absorb a same-cycle ack.
    assign w_ack_ok      = i_cell_ack && (w_outstanding != '0);
    assign w_ack_nxt     = r_ack_cnt + {{ADDRESS_WIDTH{1'b0}}, w_ack_ok};

    assign o_cell_valid  = i_enable
                        && (r_issue_cnt < CNT_W'(GRID_DIM))
                        && (w_outstanding < CNT_W'(MAX_OUTSTANDING));
    assign w_issue       = o_cell_valid && i_cell_ready;
    assign o_cell_addr   = r_issue_cnt[ADDRESS_WIDTH-1:0];
    // Looks at the post-edge count so the FSM leaves RUN on the edge where
    // the last ack lands.
    assign o_phase_complete = (w_ack_nxt == CNT_W'(GRID_DIM));
    assign o_err         = r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_issue_cnt <= '0;
            r_ack_cnt   <= '0;
        end else if (i_clear) begin
            r_issue_cnt <= '0;
            r_ack_cnt   <= '0;
        end else begin
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
            r_ack_cnt <= w_ack_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (i_cell_ack && (w_outstanding == '0)) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: rtl/lbm_step_sequencer.sv
// Sequences the LBM core through MAX_TIME time steps of
// MACRO -> COLLIDE -> STREAM, each phase sweeping every lattice cell, and
// flips the ping-pong f-buffer bank after every step.
//   CLOCK_50 : system clock
//   RESET    : async active-high reset (also a datapath flush)
//   bus      : master side of lbm_step_sequencer_if
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | issuing / collecting cells of the current phase
// GAP    | one idle cycle between phases; counters cleared, phase advanced
// FINISH | done pulse, back to IDLE next cycle
module lbm_step_sequencer
    import lbm_pkg::*;
#(
    parameter int GRID_DIM         = 256,
    parameter int MAX_TIME         = 8,
    parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME),
    parameter int ADDRESS_WIDTH    = $clog2(GRID_DIM),
    parameter int MAX_OUTSTANDING  = 4
)(
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    lbm_step_sequencer_if.master bus
);
    seq_state_t                  r_state;
    seq_state_t                  w_state_nxt;
    phase_t                      r_phase;
    logic [TIME_COUNT_WIDTH-1:0] r_time_step;
    logic                        r_buf_sel;
    logic                        w_enable;
    logic                        w_clear;
    logic                        w_phase_complete;
    logic                        w_last_step;

    assign w_last_step = (r_time_step == TIME_COUNT_WIDTH'(MAX_TIME - 1));

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (w_phase_complete) w_state_nxt = GAP;
            GAP:     w_state_nxt = (r_phase == PH_STREAM && w_last_step) ? FINISH : RUN;
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_enable = (r_state == RUN);
        w_clear  = (r_state == GAP) || (r_state == IDLE && bus.start);
        bus.busy = (r_state == RUN) || (r_state == GAP);
        bus.done = (r_state == FINISH);
    end

    // buf_sel is deliberately not cleared by start so bank alternation
    // carries across runs.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_phase     <= PH_MACRO;
            r_time_step <= '0;
            r_buf_sel   <= 1'b0;
        end else if (r_state == IDLE && bus.start) begin
            r_phase     <= PH_MACRO;
            r_time_step <= '0;
        end else if (r_state == GAP) begin
            case (r_phase)
                PH_MACRO:   r_phase <= PH_COLLIDE;
                PH_COLLIDE: r_phase <= PH_STREAM;
                default: begin
                    r_buf_sel <= ~r_buf_sel;
                    if (!w_last_step) begin
                        r_time_step <= r_time_step + TIME_COUNT_WIDTH'(1);
                        r_phase     <= PH_MACRO;
                    end
                end
            endcase
        end
    end

    assign bus.phase     = r_phase;
    assign bus.time_step = r_time_step;
    assign bus.buf_sel   = r_buf_sel;

    lbm_cell_issue_tracker #(
        .GRID_DIM        (GRID_DIM),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .ADDRESS_WIDTH   (ADDRESS_WIDTH)
    ) u_tracker (
        .i_clk            (CLOCK_50),
        .i_rst            (RESET),
        .i_enable         (w_enable),
        .i_clear          (w_clear),
        .i_cell_ready     (bus.cell_ready),
        .i_cell_ack       (bus.cell_ack),
        .o_cell_valid     (bus.cell_valid),
        .o_cell_addr      (bus.cell_addr),
        .o_phase_complete (w_phase_complete),
        .o_err            (bus.err)
    );

endmodule

// File: tb/tb_lbm_step_sequencer.sv
module tb_lbm_step_sequencer;

    localparam int GRID = 16;
    localparam int MT   = 2;
    localparam int MO   = 4;
    localparam int AW   = $clog2(GRID);
    localparam int TW   = $clog2(MT);

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    lbm_step_sequencer_if #(.ADDRESS_WIDTH(AW), .TIME_COUNT_WIDTH(TW)) sif ();

    lbm_step_sequencer #(
        .GRID_DIM(GRID), .MAX_TIME(MT), .MAX_OUTSTANDING(MO)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (sif.master)
    );

    typedef struct { int ph; int addr; int ts; int bsel; } xfer_t;
    typedef struct { int ts; int bsel; } done_t;

    xfer_t exp_q[$];
    done_t done_q[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_out   = 0;   // cells issued but not yet acknowledged
    bit m_err   = 0;
    int m_buf   = 0;   // bank expected at the start of the next run
    int n_done  = 0;
    int n_stall = 0;   // busy cycles with no cell offered

    // stimulus knobs
    int rdy_pct    = 100;
    int ack_pct    = 100;
    bit ack_en     = 1;
    bit bp_arm     = 0;
    int bp_left    = 0;
    bit rand_start = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    function automatic int code(input int ph, input int ts, input int b, input int a);
        return ph * 4096 + ts * 512 + b * 256 + a;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLOCK_50) begin
        xfer_t x;
        done_t d;
        if (RESET) begin
            exp_q.delete();
            done_q.delete();
            m_out = 0;
            m_err = 0;
        end else begin
            check(sif.err == m_err, "err_flag", int'(sif.err), int'(m_err));
            if (sif.busy && !sif.cell_valid) n_stall++;
            if (sif.cell_valid) check(m_out < MO, "outstanding_cap", m_out, MO - 1);
            if (sif.cell_valid && sif.cell_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_issue", int'(sif.cell_addr), -1);
                end else begin
                    x = exp_q.pop_front();
                    check(int'(sif.phase) == x.ph && int'(sif.cell_addr) == x.addr &&
                          int'(sif.time_step) == x.ts && int'(sif.buf_sel) == x.bsel,
                          "issue",
                          code(int'(sif.phase), int'(sif.time_step), int'(sif.buf_sel), int'(sif.cell_addr)),
                          code(x.ph, x.ts, x.bsel, x.addr));
                end
            end
            if (sif.done) begin
                n_done++;
                check(sif.busy == 1'b0, "busy_at_done", int'(sif.busy), 0);
                check(exp_q.size() == 0, "cells_left_at_done", exp_q.size(), 0);
                if (done_q.size() == 0) begin
                    check(1'b0, "unexpected_done", 1, 0);
                end else begin
                    d = done_q.pop_front();
                    check(int'(sif.time_step) == d.ts && int'(sif.buf_sel) == d.bsel, "done_state",
                          int'(sif.time_step) * 2 + int'(sif.buf_sel), d.ts * 2 + d.bsel);
                end
            end
            // advance the model across the coming edge: acks see the
            // outstanding count before this cycle's issue
            if (sif.cell_ack) begin
                if (m_out > 0) m_out--;
                else m_err = 1;
            end
            if (sif.cell_valid && sif.cell_ready) m_out++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_cycle();
        @(posedge CLOCK_50);
        #1;
        sif.start    = rand_start && sif.busy && ($urandom_range(0, 49) == 0);
        sif.cell_ack = ack_en && (m_out > 0) && ($urandom_range(0, 99) < ack_pct);
        if (bp_left > 0) begin
            check(sif.cell_valid == 1'b1 && int'(sif.cell_addr) == 5, "bp_hold", int'(sif.cell_addr), 5);
            sif.cell_ready = 1'b0;
            bp_left--;
        end else if (bp_arm && sif.cell_valid && int'(sif.cell_addr) == 5) begin
            bp_arm = 0;
            bp_left = 2;
            sif.cell_ready = 1'b0;
        end else begin
            sif.cell_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    endtask

    task automatic start_run();
        @(posedge CLOCK_50);
        #1;
        for (int t = 0; t < MT; t++)
            for (int ph = 0; ph < 3; ph++)
                for (int a = 0; a < GRID; a++)
                    exp_q.push_back('{ph, a, t, (m_buf + t) % 2});
        done_q.push_back('{MT - 1, (m_buf + MT) % 2});
        m_buf = (m_buf + MT) % 2;
        sif.start = 1'b1;
        sif.cell_ready = 1'b0;
        sif.cell_ack = 1'b0;
        drive_cycle();
        check(sif.busy == 1'b1 && sif.cell_valid == 1'b1, "start_latency",
              int'(sif.busy) * 2 + int'(sif.cell_valid), 3);
        check(int'(sif.cell_addr) == 0 && int'(sif.phase) == 0 && int'(sif.time_step) == 0,
              "start_state", code(int'(sif.phase), int'(sif.time_step), 0, int'(sif.cell_addr)), 0);
    endtask

    task automatic run_until_done(input string name);
        int d0;
        bit got;
        d0 = n_done;
        got = 0;
        for (int i = 0; i < 4000; i++) begin
            drive_cycle();
            if (n_done != d0) begin
                got = 1;
                break;
            end
        end
        check(got, {name, "_done_seen"}, int'(got), 1);
        rand_start = 0;
        repeat (3) drive_cycle();
        check(n_done == d0 + 1, {name, "_done_once"}, n_done - d0, 1);
        check(sif.busy == 1'b0, {name, "_idle_after"}, int'(sif.busy), 0);
    endtask

    task automatic check_all_zero(input string name);
        check(sif.busy == 1'b0,       {name, "_busy"},  int'(sif.busy), 0);
        check(sif.done == 1'b0,       {name, "_done"},  int'(sif.done), 0);
        check(int'(sif.phase) == 0,   {name, "_phase"}, int'(sif.phase), 0);
        check(sif.cell_valid == 1'b0, {name, "_valid"}, int'(sif.cell_valid), 0);
        check(int'(sif.cell_addr) == 0, {name, "_addr"}, int'(sif.cell_addr), 0);
        check(sif.buf_sel == 1'b0,    {name, "_buf"},   int'(sif.buf_sel), 0);
        check(int'(sif.time_step) == 0, {name, "_ts"},  int'(sif.time_step), 0);
        check(sif.err == 1'b0,        {name, "_err"},   int'(sif.err), 0);
    endtask

    initial begin
        bit found;
        sif.start = 1'b0;
        sif.cell_ready = 1'b0;
        sif.cell_ack = 1'b0;

        // reset values, then idle with start low
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_all_zero("reset");
        RESET = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_cycle();
            check(sif.busy == 1'b0 && sif.cell_valid == 1'b0, "idle_hold",
                  int'(sif.busy) * 2 + int'(sif.cell_valid), 0);
        end

        // full-throughput run: ack one cycle after each issue
        rdy_pct = 100; ack_pct = 100; ack_en = 1;
        n_stall = 0;
        start_run();
        run_until_done("full");
        // per phase: one cycle waiting on the last ack, then the GAP cycle
        check(n_stall == 6 * MT, "full_stall_cycles", n_stall, 6 * MT);

        // backpressure at address 5
        bp_arm = 1;
        start_run();
        run_until_done("bp");
        check(bp_arm == 0 && bp_left == 0, "bp_triggered", int'(bp_arm) + bp_left, 0);

        // outstanding cap with acks withheld
        ack_en = 0;
        start_run();
        repeat (10) drive_cycle();
        check(sif.cell_valid == 1'b0, "cap_valid_low", int'(sif.cell_valid), 0);
        check(int'(sif.cell_addr) == MO, "cap_addr", int'(sif.cell_addr), MO);
        check(m_out == MO, "cap_outstanding", m_out, MO);
        @(posedge CLOCK_50);
        #1;
        sif.cell_ack = 1'b1;
        @(posedge CLOCK_50);
        #1;
        sif.cell_ack = 1'b0;
        check(sif.cell_valid == 1'b1 && int'(sif.cell_addr) == MO, "cap_release",
              int'(sif.cell_valid) * 256 + int'(sif.cell_addr), 256 + MO);
        ack_en = 1;
        run_until_done("cap");

        // spurious ack in IDLE, then a normal run with err still set
        @(posedge CLOCK_50);
        #1;
        sif.cell_ack = 1'b1;
        @(posedge CLOCK_50);
        #1;
        sif.cell_ack = 1'b0;
        check(sif.err == 1'b1, "spurious_err", int'(sif.err), 1);
        check(sif.busy == 1'b0, "spurious_stays_idle", int'(sif.busy), 0);
        repeat (3) drive_cycle();
        rdy_pct = 60; ack_pct = 50;
        start_run();
        run_until_done("after_spurious");
        check(sif.err == 1'b1, "err_sticky", int'(sif.err), 1);

        // randomized runs, including ignored start pulses while busy
        for (int r = 0; r < 4; r++) begin
            rdy_pct = $urandom_range(30, 100);
            ack_pct = $urandom_range(20, 100);
            start_run();
            rand_start = 1;
            run_until_done("random");
        end

        // reset in the middle of STREAM of the last step
        rdy_pct = 100; ack_pct = 70;
        start_run();
        found = 0;
        for (int i = 0; i < 4000; i++) begin
            drive_cycle();
            if (sif.busy && int'(sif.phase) == 2 && int'(sif.time_step) == MT - 1) begin
                found = 1;
                break;
            end
        end
        check(found, "reach_last_stream", int'(found), 1);
        repeat (4) drive_cycle();
        #2;
        RESET = 1'b1;
        sif.cell_ack = 1'b0;
        sif.start = 1'b0;
        sif.cell_ready = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;
        m_buf = 0;
        rdy_pct = 100; ack_pct = 100;
        start_run();
        run_until_done("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
